// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage with IF/ID pipeline register.
// Owns the PC, drives a req/ack instruction-memory port and squashes wrong-path fetches.
module if_fetch_stage #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   input  logic        stall,
   input  logic        Branch,
   input  logic [31:0] branch_target,
   output logic        id_valid,
   output logic [31:0] id_pc,
   output logic [31:0] id_instr
);

   typedef enum logic [1:0] {IDLE, FETCH, HOLD, KILL} state_t;

   state_t      state, state_nx;
   logic [31:0] pc;
   logic [31:0] kill_addr;
   logic [31:0] hold_buf;
   logic [31:0] target_al;
   logic        redirect;

   always_comb begin
      redirect  = Branch & id_valid & ~stall;
      target_al = branch_target & 32'hFFFF_FFFC;
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:  state_nx = FETCH;
         FETCH: begin
            // A redirect with no ack leaves a wrong-path request in flight; KILL drains it.
            if (redirect)               state_nx = imem_ack ? FETCH : KILL;
            else if (imem_ack && stall) state_nx = HOLD;
         end
         HOLD:  if (redirect || !stall) state_nx = FETCH;
         KILL:  if (imem_ack) state_nx = FETCH;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      imem_req  = (state == FETCH) || (state == KILL);
      imem_addr = (state == KILL) ? kill_addr : pc;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc        <= RESET_PC;
         id_valid  <= 1'b0;
         id_pc     <= '0;
         id_instr  <= NOP_INSTR;
         kill_addr <= '0;
         hold_buf  <= '0;
      end else begin
         case (state)
            FETCH: begin
               if (redirect) begin
                  pc       <= target_al;
                  id_valid <= 1'b0;
                  id_instr <= NOP_INSTR;
                  if (!imem_ack) kill_addr <= pc;
               end else if (imem_ack && !stall) begin
                  id_pc    <= pc;
                  id_instr <= imem_rdata;
                  id_valid <= 1'b1;
                  pc       <= pc + 32'd4;
               end else if (imem_ack) begin
                  hold_buf <= imem_rdata;
               end else if (!stall) begin
                  id_valid <= 1'b0;
               end
            end
            HOLD: begin
               if (redirect) begin
                  pc       <= target_al;
                  id_valid <= 1'b0;
               end else if (!stall) begin
                  id_pc    <= pc;
                  id_instr <= hold_buf;
                  id_valid <= 1'b1;
                  pc       <= pc + 32'd4;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: directed vector table, then random traffic against a
// transaction-level model (outstanding request, wrong-path flag, one-entry buffer).
module tb_if_fetch_stage;

   localparam logic [31:0] RPC = 32'h0000_0100;
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst, imem_ack, stall, Branch;
   logic [31:0] imem_rdata, branch_target;
   logic        imem_req, id_valid;
   logic [31:0] imem_addr, id_pc, id_instr;

   int tests = 0;
   int failed = 0;

   if_fetch_stage #(.RESET_PC(RPC), .NOP_INSTR(NOP)) dut (
      .clk(clk), .rst(rst),
      .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .stall(stall), .Branch(Branch), .branch_target(branch_target),
      .id_valid(id_valid), .id_pc(id_pc), .id_instr(id_instr)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rst, ack;
      logic [31:0] rdata;
      logic        stall, br;
      logic [31:0] tgt;
      logic        e_req;
      logic [31:0] e_addr;
      logic        e_val;
      logic [31:0] e_pc, e_ins;
   } vec_t;

   vec_t tbl[30];

   function automatic vec_t v(logic r, logic a, logic [31:0] d, logic s, logic b, logic [31:0] t,
                              logic eq, logic [31:0] ea, logic ev, logic [31:0] ep, logic [31:0] ei);
      vec_t x;
      x.rst = r; x.ack = a; x.rdata = d; x.stall = s; x.br = b; x.tgt = t;
      x.e_req = eq; x.e_addr = ea; x.e_val = ev; x.e_pc = ep; x.e_ins = ei;
      return x;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference model: which request is outstanding and whether its data is wanted.
   logic        m_started, m_busy, m_drop, m_val;
   logic [31:0] m_pc, m_addr, m_idpc, m_ins;
   logic [31:0] m_buf[$];

   task automatic model_step(input logic r, input logic a, input logic [31:0] d,
                             input logic s, input logic b, input logic [31:0] t);
      logic redir, got;
      redir = b & m_val & ~s;
      got   = a & m_busy;
      if (r) begin
         m_started = 0; m_busy = 0; m_drop = 0; m_val = 0;
         m_pc = RPC; m_addr = RPC; m_idpc = 0; m_ins = NOP;
         m_buf.delete();
      end else if (!m_started) begin
         m_started = 1; m_busy = 1; m_addr = m_pc;
      end else if (m_drop) begin
         if (got) begin m_drop = 0; m_addr = m_pc; end
      end else if (m_buf.size() != 0) begin
         if (redir) begin
            m_buf.delete(); m_pc = {t[31:2], 2'b00}; m_val = 0;
            m_busy = 1; m_addr = m_pc;
         end else if (!s) begin
            m_idpc = m_pc; m_ins = m_buf.pop_front(); m_val = 1;
            m_pc = m_pc + 4; m_busy = 1; m_addr = m_pc;
         end
      end else begin
         if (redir) begin
            m_pc = {t[31:2], 2'b00}; m_val = 0; m_ins = NOP;
            if (got) m_addr = m_pc;
            else     m_drop = 1;
         end else if (got && !s) begin
            m_idpc = m_pc; m_ins = d; m_val = 1; m_pc = m_pc + 4; m_addr = m_pc;
         end else if (got) begin
            m_buf.push_back(d); m_busy = 0;
         end else if (!s) begin
            m_val = 0;
         end
      end
   endtask

   initial begin
      // rst ack rdata stall br tgt | req addr val id_pc id_instr
      tbl[0]  = v(0,0,0,0,0,0,                           0,RPC,0,0,NOP);
      tbl[1]  = v(0,1,32'h0050_0093,0,0,0,               1,32'h100,0,0,NOP);
      tbl[2]  = v(0,0,0,0,0,0,                           1,32'h104,1,32'h100,32'h0050_0093);
      tbl[3]  = v(0,0,0,0,0,0,                           1,32'h104,0,32'h100,32'h0050_0093);
      tbl[4]  = v(0,0,0,0,0,0,                           1,32'h104,0,32'h100,32'h0050_0093);
      tbl[5]  = v(0,1,32'h00A0_0113,0,0,0,               1,32'h104,0,32'h100,32'h0050_0093);
      tbl[6]  = v(0,1,32'h00F0_0193,1,0,0,               1,32'h108,1,32'h104,32'h00A0_0113);
      tbl[7]  = v(0,0,0,1,0,0,                           0,32'h108,1,32'h104,32'h00A0_0113);
      tbl[8]  = v(0,0,0,1,0,0,                           0,32'h108,1,32'h104,32'h00A0_0113);
      tbl[9]  = v(0,0,0,0,0,0,                           0,32'h108,1,32'h104,32'h00A0_0113);
      tbl[10] = v(0,1,32'hDEAD_BEEF,0,1,32'h200,         1,32'h10C,1,32'h108,32'h00F0_0193);
      tbl[11] = v(0,0,0,0,0,0,                           1,32'h200,0,32'h108,NOP);
      tbl[12] = v(0,1,32'h0000_0297,0,0,0,               1,32'h200,0,32'h108,NOP);
      tbl[13] = v(0,0,0,0,1,32'h203,                     1,32'h204,1,32'h200,32'h0000_0297);
      tbl[14] = v(0,0,0,0,0,0,                           1,32'h204,0,32'h200,NOP);
      tbl[15] = v(0,1,32'hBADB_AD00,0,0,0,               1,32'h204,0,32'h200,NOP);
      tbl[16] = v(0,1,32'h0010_0313,0,0,0,               1,32'h200,0,32'h200,NOP);
      tbl[17] = v(0,0,0,1,1,32'h300,                     1,32'h204,1,32'h200,32'h0010_0313);
      tbl[18] = v(0,1,32'h1111_1111,1,1,32'h300,         1,32'h204,1,32'h200,32'h0010_0313);
      tbl[19] = v(0,0,0,0,1,32'h300,                     0,32'h204,1,32'h200,32'h0010_0313);
      tbl[20] = v(0,0,0,0,0,0,                           1,32'h300,0,32'h200,32'h0010_0313);
      tbl[21] = v(0,1,32'h2222_2222,0,0,0,               1,32'h300,0,32'h200,32'h0010_0313);
      tbl[22] = v(0,1,32'h0000_0033,0,1,32'hFFFF_FFFC,   1,32'h304,1,32'h300,32'h2222_2222);
      tbl[23] = v(0,1,32'h4444_4444,0,0,0,               1,32'hFFFF_FFFC,0,32'h300,NOP);
      tbl[24] = v(0,0,0,0,0,0,                           1,32'h0,1,32'hFFFF_FFFC,32'h4444_4444);
      tbl[25] = v(1,1,32'h7777_7777,0,0,0,               1,32'h0,0,32'hFFFF_FFFC,32'h4444_4444);
      tbl[26] = v(0,1,32'h5555_5555,0,0,0,               0,RPC,0,0,NOP);
      tbl[27] = v(0,0,0,0,0,0,                           1,RPC,0,0,NOP);
      tbl[28] = v(0,1,32'h0000_0066,0,0,0,               1,RPC,0,0,NOP);
      tbl[29] = v(0,0,0,0,0,0,                           1,32'h104,1,32'h100,32'h0000_0066);

      rst = 1; imem_ack = 0; imem_rdata = 0; stall = 0; Branch = 0; branch_target = 0;
      repeat (2) @(posedge clk);

      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         rst = tbl[i].rst; imem_ack = tbl[i].ack; imem_rdata = tbl[i].rdata;
         stall = tbl[i].stall; Branch = tbl[i].br; branch_target = tbl[i].tgt;
         check($sformatf("vec%0d.req", i),   {31'b0, imem_req}, {31'b0, tbl[i].e_req});
         check($sformatf("vec%0d.addr", i),  imem_addr,         tbl[i].e_addr);
         check($sformatf("vec%0d.valid", i), {31'b0, id_valid}, {31'b0, tbl[i].e_val});
         check($sformatf("vec%0d.id_pc", i), id_pc,             tbl[i].e_pc);
         check($sformatf("vec%0d.instr", i), id_instr,          tbl[i].e_ins);
      end

      @(negedge clk);
      rst = 1; imem_ack = 0; stall = 0; Branch = 0;
      @(posedge clk);
      model_step(1, 0, 0, 0, 0, 0);

      for (int c = 0; c < 4000; c++) begin
         @(negedge clk);
         check($sformatf("rnd%0d.req", c),   {31'b0, imem_req}, {31'b0, m_busy});
         check($sformatf("rnd%0d.addr", c),  imem_addr,         m_addr);
         check($sformatf("rnd%0d.valid", c), {31'b0, id_valid}, {31'b0, m_val});
         check($sformatf("rnd%0d.id_pc", c), id_pc,             m_idpc);
         check($sformatf("rnd%0d.instr", c), id_instr,          m_ins);
         rst           = ($urandom_range(0, 199) == 0);
         imem_ack      = ($urandom_range(0, 9) < 6);
         imem_rdata    = $urandom;
         stall         = ($urandom_range(0, 9) < 3);
         Branch        = ($urandom_range(0, 9) < 3);
         branch_target = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15))
                                                     : $urandom;
         @(posedge clk);
         model_step(rst, imem_ack, imem_rdata, stall, Branch, branch_target);
      end

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
